seg7_scan_driver: RTL and testbench

Time-multiplexed seven-segment scan driver that sits directly downstream of the calculator entry register. It consumes the 20-bit, five-nibble display word (nibble 4 = leftmost digit) and drives one shared segment bus plus five digit enables, one digit at a time. It applies leading-zero blanking, renders nibble 0xF as a minus sign, and samples the input only at frame boundaries so the panel never shows a torn value.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and scan-state encoding.
// Patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Nibble code the entry register uses for a leading minus sign.
    localparam logic [3:0] MINUS_CODE = 4'hF;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } seg7_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment pattern.
// Codes 0xA-0xE have no glyph and decode to all segments off.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0:       seg_o = SEG_0;
            4'h1:       seg_o = SEG_1;
            4'h2:       seg_o = SEG_2;
            4'h3:       seg_o = SEG_3;
            4'h4:       seg_o = SEG_4;
            4'h5:       seg_o = SEG_5;
            4'h6:       seg_o = SEG_6;
            4'h7:       seg_o = SEG_7;
            4'h8:       seg_o = SEG_8;
            4'h9:       seg_o = SEG_9;
            MINUS_CODE: seg_o = SEG_MINUS;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with guard gaps, leading-zero
// blanking and frame-boundary snapshots of the display word.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 5,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 500
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_zeros,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned PreMax = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int unsigned PreW   = (PreMax > 1) ? $clog2(PreMax) : 1;
    localparam int unsigned DigW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PreW-1:0]       GuardLast = PreW'(GUARD_CYCLES - 1);
    localparam logic [PreW-1:0]       DriveLast = PreW'(REFRESH_DIV - 1);
    localparam logic [DigW-1:0]       DigLast   = DigW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AnOne     = NUM_DIGITS'(1);

    seg7_state_e                 state_q, state_d;
    logic [PreW-1:0]             pre_q, pre_d;
    logic [DigW-1:0]             digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0]     snap_q, snap_d;
    logic                        bz_q, bz_d;
    logic [NUM_DIGITS-1:0]       mask_q, mask_d;
    logic                        first_q, first_d;
    logic [6:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic                        fd_q, fd_d;

    logic                        wrap;
    logic                        take;
    logic                        zero_run;
    logic [3:0]                  cur_nib;
    logic                        cur_blank;
    logic [6:0]                  cur_pat;

    // Scan sequencing: GUARD gap then DRIVE per digit.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q + PreW'(1);
        digit_d = digit_q;
        wrap    = 1'b0;
        unique case (state_q)
            GUARD: begin
                if (pre_q == GuardLast) begin
                    state_d = DRIVE;
                    pre_d   = '0;
                end
            end
            DRIVE: begin
                if (pre_q == DriveLast) begin
                    state_d = GUARD;
                    pre_d   = '0;
                    if (digit_q == DigLast) begin
                        digit_d = '0;
                        wrap    = 1'b1;
                    end else begin
                        digit_d = digit_q + DigW'(1);
                    end
                end
            end
            default: begin
                state_d = GUARD;
                pre_d   = '0;
            end
        endcase
    end

    // Snapshot on frame wrap, plus once on the first edge out of reset.
    always_comb begin
        take     = wrap | first_q;
        first_d  = 1'b0;
        fd_d     = wrap;
        snap_d   = take ? value : snap_q;
        bz_d     = take ? blank_zeros : bz_q;
        mask_d   = '0;
        zero_run = bz_d;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run  = zero_run && (snap_d[4*i +: 4] == 4'h0);
            mask_d[i] = zero_run;
        end
        if (!take) begin
            mask_d = mask_q;
        end
    end

    // Select the nibble for the digit about to be shown.
    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_d == DigW'(i)) begin
                cur_nib   = snap_d[4*i +: 4];
                cur_blank = mask_d[i];
            end
        end
    end

    seg7_decode u_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_pat)
    );

    // Outputs follow the next state so DRIVE's first cycle already shows the digit.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (state_d == DRIVE && !cur_blank && cur_pat != SEG_BLANK) begin
            seg_d = cur_pat;
            an_d  = ~(AnOne << digit_d);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= GUARD;
            pre_q   <= '0;
            digit_q <= '0;
            snap_q  <= '0;
            bz_q    <= 1'b0;
            mask_q  <= '0;
            first_q <= 1'b1;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            bz_q    <= bz_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, GUARD_CYCLES=2
// (digit period 6 clocks, frame period 30 clocks).
module tb_seg7_scan_driver;

    logic        clock;
    logic        reset;
    logic [19:0] value;
    logic        blank_zeros;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (5),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .value       (value),
        .blank_zeros (blank_zeros),
        .seg         (seg),
        .an          (an),
        .frame_done  (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input logic [19:0] v, input logic bz);
        @(negedge clock);
        reset       = 1'b1;
        value       = v;
        blank_zeros = bz;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Walks edges 1..26 after release: initial guard, every guard gap and DRIVE entry.
    task automatic check_frame(input string name, input logic [34:0] es, input logic [24:0] ea);
        step();
        check_eq({name, " e1 an"}, 32'(an), 32'h1F);
        check_eq({name, " e1 seg"}, 32'(seg), 32'h7F);
        check_eq({name, " e1 fd"}, 32'(frame_done), 32'h0);
        step();
        check_eq({name, " d0 seg"}, 32'(seg), 32'(es[6:0]));
        check_eq({name, " d0 an"}, 32'(an), 32'(ea[4:0]));
        for (int d = 1; d < 5; d++) begin
            repeat (4) step();
            check_eq($sformatf("%s g%0d an", name, d), 32'(an), 32'h1F);
            check_eq($sformatf("%s g%0d seg", name, d), 32'(seg), 32'h7F);
            repeat (2) step();
            check_eq($sformatf("%s d%0d seg", name, d), 32'(seg), 32'(es[7*d +: 7]));
            check_eq($sformatf("%s d%0d an", name, d), 32'(an), 32'(ea[5*d +: 5]));
        end
    endtask

    initial begin
        int fd_seen;
        reset       = 1'b1;
        value       = '0;
        blank_zeros = 1'b0;
        #1;
        check_eq("rst an", 32'(an), 32'h1F);
        check_eq("rst seg", 32'(seg), 32'h7F);
        check_eq("rst fd", 32'(frame_done), 32'h0);

        // Vectors packed {d4,d3,d2,d1,d0}.
        apply_reset(20'h00042, 1'b1);
        check_frame("v42", {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24},
                    {5'h1F, 5'h1F, 5'h1F, 5'h1D, 5'h1E});

        apply_reset(20'hF0007, 1'b1);
        check_frame("vF7", {7'h3F, 7'h40, 7'h40, 7'h40, 7'h78},
                    {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E});

        apply_reset(20'h00000, 1'b1);
        check_frame("z_bz1", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                    {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1E});

        apply_reset(20'h00000, 1'b0);
        check_frame("z_bz0", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
                    {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E});

        apply_reset(20'h38629, 1'b1);
        check_frame("v38629", {7'h30, 7'h00, 7'h02, 7'h24, 7'h10},
                    {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E});

        // 0xA has no glyph: digit dark even without zero blanking.
        apply_reset(20'h000A5, 1'b0);
        check_frame("vA5", {7'h40, 7'h40, 7'h40, 7'h7F, 7'h12},
                    {5'h0F, 5'h17, 5'h1B, 5'h1F, 5'h1E});

        // Mid-frame value change is invisible until the wrap snapshot.
        apply_reset(20'h00001, 1'b1);
        repeat (2) step();
        check_eq("chg d0 seg", 32'(seg), 32'h79);
        check_eq("chg d0 an", 32'(an), 32'h1E);
        repeat (6) step();
        check_eq("chg d1 an", 32'(an), 32'h1F);
        repeat (2) step();
        value = 20'h00009;
        repeat (19) step();
        check_eq("chg e29 fd", 32'(frame_done), 32'h0);
        step();
        check_eq("chg e30 fd", 32'(frame_done), 32'h1);
        check_eq("chg e30 an", 32'(an), 32'h1F);
        check_eq("chg e30 seg", 32'(seg), 32'h7F);
        step();
        check_eq("chg e31 fd", 32'(frame_done), 32'h0);
        step();
        check_eq("chg new d0 seg", 32'(seg), 32'h10);
        check_eq("chg new d0 an", 32'(an), 32'h1E);

        // Reset during DRIVE of digit 3.
        apply_reset(20'h01234, 1'b1);
        repeat (21) step();
        check_eq("mid d3 seg", 32'(seg), 32'h79);
        check_eq("mid d3 an", 32'(an), 32'h17);
        #2;
        reset = 1'b1;
        value = 20'h00056;
        #1;
        check_eq("mid async an", 32'(an), 32'h1F);
        check_eq("mid async seg", 32'(seg), 32'h7F);
        check_eq("mid async fd", 32'(frame_done), 32'h0);
        @(negedge clock);
        reset   = 1'b0;
        fd_seen = 0;
        for (int e = 1; e < 30; e++) begin
            step();
            if (frame_done) fd_seen++;
            if (e == 1) begin
                check_eq("post e1 an", 32'(an), 32'h1F);
            end else if (e == 2) begin
                check_eq("post d0 seg", 32'(seg), 32'h02);
                check_eq("post d0 an", 32'(an), 32'h1E);
            end else if (e == 8) begin
                check_eq("post d1 seg", 32'(seg), 32'h12);
                check_eq("post d1 an", 32'(an), 32'h1D);
            end else if (e == 14) begin
                check_eq("post d2 an", 32'(an), 32'h1F);
            end
        end
        check_eq("post no fd pulse", 32'(fd_seen), 32'h0);
        step();
        check_eq("post e30 fd", 32'(frame_done), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
